cw_iambic_keyer: RTL and testbench

- Iambic paddle keyer that turns debounced dot/dash paddle inputs into a timed Morse key signal.
- Sits directly upstream of the CW sequencer. Its keyer_out drives that sequencer's cwx input, which provides the T/R delay and hang timing.
- Configured over the command bus. All element timing is in msec_pulse ticks.

---
 rtl/cw_iambic_keyer_if.sv | 8 +
 rtl/cw_iambic_keyer.sv | 187 ++++++++++++++++++
 tb/tb_cw_iambic_keyer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cw_iambic_keyer_if.sv
// cw_iambic_keyer_if: command bus carrying config writes into the keyer
interface cw_iambic_keyer_if;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_rqst;
    modport master (output cmd_addr, cmd_data, cmd_rqst);
    modport slave  (input  cmd_addr, cmd_data, cmd_rqst);
endinterface

// File: rtl/cw_iambic_keyer.sv
// cw_iambic_keyer: iambic A/B and straight paddle keyer timed in msec_pulse ticks
module cw_iambic_keyer #(
    parameter logic [5:0] CFG_ADDR    = 6'h11,
    parameter int         DEFAULT_WPM = 20,
    parameter int         MAX_WPM     = 60
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cw_iambic_keyer_if.slave         cmd,
    input  logic                     msec_pulse,
    input  logic                     dot_key_debounced,
    input  logic                     dash_key_debounced,
    output logic                     keyer_out,
    output logic                     keyer_active
);
    typedef enum logic [1:0] {IDLE, DOT, DASH, GAP} state_t;
    localparam logic [5:0]  MAX6    = 6'(MAX_WPM);
    localparam logic [5:0]  DEF6    = 6'(DEFAULT_WPM);
    localparam logic [10:0] DEF_DOT = 11'(1200 / DEFAULT_WPM);

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic        dot_mem_q, dot_mem_d, dash_mem_q, dash_mem_d;
    logic        last_q, last_d, key_q, key_d;
    logic        enable_q, enable_d, reverse_q, reverse_d;
    logic [1:0]  mode_q, mode_d;
    logic [5:0]  wpm_q, wpm_d;
    logic [10:0] dot_ms_q, dot_ms_d;
    logic        div_busy_q, div_busy_d;
    logic [3:0]  div_cnt_q, div_cnt_d;
    logic [10:0] div_quo_q, div_quo_d;
    logic [5:0]  div_rem_q, div_rem_d;
    logic [6:0]  trial;
    logic        ge, wr, dot_p, dash_p, iambic, mode_b, opp, same, go_dot, go_dash;
    logic [5:0]  wpm_in;
    logic [11:0] dot_len, dash_len;
    logic        unused_cmd_bits;

    assign unused_cmd_bits = ^cmd.cmd_data[31:10];
    assign wr       = cmd.cmd_rqst && (cmd.cmd_addr == CFG_ADDR);
    assign wpm_in   = cmd.cmd_data[5:0];
    assign dot_p    = reverse_q ? dash_key_debounced : dot_key_debounced;
    assign dash_p   = reverse_q ? dot_key_debounced : dash_key_debounced;
    assign iambic   = (mode_q == 2'b01) || (mode_q == 2'b10);
    assign mode_b   = (mode_q == 2'b10);
    assign dot_len  = 12'(dot_ms_q);
    assign dash_len = 12'(dot_ms_q) * 12'd3;
    assign trial    = {div_rem_q, div_quo_q[10]};
    assign ge       = trial >= {1'b0, wpm_q};
    // last_q=1 means the previous element was a dash, so the opposite is a dot
    assign opp      = last_q ? (dot_p | (mode_b & dot_mem_q)) : (dash_p | (mode_b & dash_mem_q));
    assign same     = last_q ? dash_p : dot_p;
    assign keyer_out    = key_q;
    assign keyer_active = (state_q != IDLE) | key_q;

    always_comb begin
        enable_d   = enable_q;
        reverse_d  = reverse_q;
        mode_d     = mode_q;
        wpm_d      = wpm_q;
        dot_ms_d   = dot_ms_q;
        div_busy_d = div_busy_q;
        div_cnt_d  = div_cnt_q;
        div_quo_d  = div_quo_q;
        div_rem_d  = div_rem_q;
        if (div_busy_q) begin
            div_quo_d = {div_quo_q[9:0], ge};
            div_rem_d = ge ? 6'(trial - {1'b0, wpm_q}) : trial[5:0];
            div_cnt_d = div_cnt_q - 4'd1;
            if (div_cnt_q == 4'd1) begin
                div_busy_d = 1'b0;
                dot_ms_d   = {div_quo_q[9:0], ge};
            end
        end
        if (wr) begin
            wpm_d      = (wpm_in == 6'd0) ? 6'd1 : (wpm_in > MAX6) ? MAX6 : wpm_in;
            mode_d     = cmd.cmd_data[7:6];
            reverse_d  = cmd.cmd_data[8];
            enable_d   = cmd.cmd_data[9];
            div_busy_d = 1'b1;
            div_cnt_d  = 4'd11;
            div_quo_d  = 11'd1200;
            div_rem_d  = 6'd0;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dot_mem_d  = dot_mem_q;
        dash_mem_d = dash_mem_q;
        last_d     = last_q;
        key_d      = key_q;
        go_dot     = 1'b0;
        go_dash    = 1'b0;
        if (!enable_q) begin
            state_d    = IDLE;
            key_d      = 1'b0;
            dot_mem_d  = 1'b0;
            dash_mem_d = 1'b0;
        end else if (!iambic) begin
            state_d    = IDLE;
            dot_mem_d  = 1'b0;
            dash_mem_d = 1'b0;
            key_d      = msec_pulse ? dot_p : key_q;
        end else if (msec_pulse) begin
            // Mode B only remembers the paddle opposite the element in progress
            if (mode_b && (state_q == DOT || (state_q == GAP && !last_q)) && dash_p)
                dash_mem_d = 1'b1;
            if (mode_b && (state_q == DASH || (state_q == GAP && last_q)) && dot_p)
                dot_mem_d = 1'b1;
            if (state_q != IDLE)
                cnt_d = cnt_q - 12'd1;
            unique case (state_q)
                IDLE: begin
                    go_dot  = dot_p;
                    go_dash = !dot_p && dash_p;
                    if (mode_b && dot_p && dash_p)
                        dash_mem_d = 1'b1;
                end
                DOT, DASH: if (cnt_q == 12'd1) begin
                    state_d = GAP;
                    cnt_d   = dot_len;
                    key_d   = 1'b0;
                    last_d  = (state_q == DASH);
                end
                GAP: if (cnt_q == 12'd1) begin
                    go_dot  = last_q ? opp : (!opp && same);
                    go_dash = last_q ? (!opp && same) : opp;
                    if (!opp && !same) begin
                        state_d    = IDLE;
                        dot_mem_d  = 1'b0;
                        dash_mem_d = 1'b0;
                    end
                end
            endcase
            if (go_dot) begin
                state_d   = DOT;
                cnt_d     = dot_len;
                key_d     = 1'b1;
                dot_mem_d = 1'b0;
            end
            if (go_dash) begin
                state_d    = DASH;
                cnt_d      = dash_len;
                key_d      = 1'b1;
                dash_mem_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dot_mem_q  <= 1'b0;
            dash_mem_q <= 1'b0;
            last_q     <= 1'b0;
            key_q      <= 1'b0;
            enable_q   <= 1'b0;
            reverse_q  <= 1'b0;
            mode_q     <= 2'b10;
            wpm_q      <= DEF6;
            dot_ms_q   <= DEF_DOT;
            div_busy_q <= 1'b0;
            div_cnt_q  <= '0;
            div_quo_q  <= '0;
            div_rem_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dot_mem_q  <= dot_mem_d;
            dash_mem_q <= dash_mem_d;
            last_q     <= last_d;
            key_q      <= key_d;
            enable_q   <= enable_d;
            reverse_q  <= reverse_d;
            mode_q     <= mode_d;
            wpm_q      <= wpm_d;
            dot_ms_q   <= dot_ms_d;
            div_busy_q <= div_busy_d;
            div_cnt_q  <= div_cnt_d;
            div_quo_q  <= div_quo_d;
            div_rem_q  <= div_rem_d;
        end
    end
endmodule

// File: tb/tb_cw_iambic_keyer.sv
// tb_cw_iambic_keyer: scoreboard of expected mark/gap lengths against measured keyer_out
module tb_cw_iambic_keyer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic msec_pulse = 1'b0;
    logic dot_key = 1'b0;
    logic dash_key = 1'b0;
    logic keyer_out, keyer_active;
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_hi[$];
    int   exp_gap[$];
    logic mon_en = 1'b0;
    logic prev = 1'b0;
    logic gap_ok = 1'b0;
    int   seg = 0;
    int   ph = 0;

    cw_iambic_keyer_if bus ();

    cw_iambic_keyer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cmd                (bus),
        .msec_pulse         (msec_pulse),
        .dot_key_debounced  (dot_key),
        .dash_key_debounced (dash_key),
        .keyer_out          (keyer_out),
        .keyer_active       (keyer_active)
    );

    always #5 clk = ~clk;

    // one tick every 4 clocks keeps element lengths short in simulation time
    initial forever begin
        @(negedge clk);
        ph = ph + 1;
        msec_pulse = (ph % 4 == 0);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // keyer_out edges always land one clock after a tick, so clocks/4 = ticks
    always @(negedge clk) begin
        if (keyer_out !== prev) begin
            if (mon_en) begin
                if (prev) begin
                    if (exp_hi.size() != 0) chk("mark_len", seg / 4, exp_hi.pop_front());
                    else chk("mark_unexpected", seg / 4, 0);
                end else if (gap_ok) begin
                    if (exp_gap.size() != 0) chk("gap_len", seg / 4, exp_gap.pop_front());
                    else chk("gap_unexpected", seg / 4, 0);
                end
            end
            gap_ok = mon_en;
            seg = 1;
            prev = keyer_out;
        end else begin
            seg++;
        end
        if (!keyer_out && !keyer_active) gap_ok = 1'b0;
    end

    function automatic logic [31:0] cfg(input int wpm, input int mode, input bit rev, input bit en);
        return 32'(wpm & 63) | (32'(mode & 3) << 6) | (32'(rev) << 8) | (32'(en) << 9);
    endfunction

    task automatic wr_cfg(input logic [31:0] d);
        @(negedge clk);
        bus.cmd_addr = 6'h11;
        bus.cmd_data = d;
        bus.cmd_rqst = 1'b1;
        @(negedge clk);
        bus.cmd_rqst = 1'b0;
    endtask

    task automatic tick_wait(input int n);
        repeat (n) @(posedge clk iff msec_pulse);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 4000 && keyer_active; i++) @(negedge clk);
        chk(tag, int'(keyer_active), 0);
        tick_wait(2);
        chk({tag, "_marks_left"}, exp_hi.size(), 0);
        chk({tag, "_gaps_left"}, exp_gap.size(), 0);
    endtask

    initial begin
        bus.cmd_addr = '0;
        bus.cmd_data = '0;
        bus.cmd_rqst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", int'(keyer_out), 0);
        chk("rst_active", int'(keyer_active), 0);
        chk("rst_dot_ms", int'(dut.dot_ms_q), 60);
        rst_n = 1'b1;
        mon_en = 1'b1;
        wr_cfg(cfg(20, 2, 0, 1));
        tick_wait(1);

        // hold dot: 60/60 repeating, released inside the third dot
        exp_hi = '{60, 60, 60};
        exp_gap = '{60, 60};
        dot_key = 1'b1;
        tick_wait(90);
        chk("dot_gap_active", int'(keyer_active), 1);
        chk("dot_gap_out", int'(keyer_out), 0);
        tick_wait(160);
        dot_key = 1'b0;
        wait_idle("dot_hold");

        // hold dash: 180/60, released inside the second gap
        exp_hi = '{180, 180};
        exp_gap = '{60};
        dash_key = 1'b1;
        tick_wait(441);
        dash_key = 1'b0;
        wait_idle("dash_hold");

        // mode B squeeze released 10 ticks into the dash adds a trailing dot
        exp_hi = '{60, 180, 60};
        exp_gap = '{60, 60};
        dot_key = 1'b1;
        dash_key = 1'b1;
        tick_wait(131);
        dot_key = 1'b0;
        dash_key = 1'b0;
        wait_idle("squeeze_b");

        wr_cfg(cfg(20, 1, 0, 1));
        tick_wait(1);
        exp_hi = '{60, 180};
        exp_gap = '{60};
        dot_key = 1'b1;
        dash_key = 1'b1;
        tick_wait(131);
        dot_key = 1'b0;
        dash_key = 1'b0;
        wait_idle("squeeze_a");

        wr_cfg(cfg(0, 1, 0, 1));
        chk("div_hold_old", int'(dut.dot_ms_q), 60);
        repeat (16) @(negedge clk);
        chk("wpm0_clamp", int'(dut.wpm_q), 1);
        chk("wpm0_dot_ms", int'(dut.dot_ms_q), 1200);
        wr_cfg(cfg(63, 1, 0, 1));
        repeat (16) @(negedge clk);
        chk("wpm63_clamp", int'(dut.wpm_q), 60);
        chk("wpm63_dot_ms", int'(dut.dot_ms_q), 20);
        wr_cfg(cfg(0, 1, 0, 1));
        repeat (3) @(negedge clk);
        wr_cfg(cfg(40, 1, 0, 1));
        repeat (16) @(negedge clk);
        chk("div_restart", int'(dut.dot_ms_q), 30);

        // speed change mid-dot keeps that dot at its starting length
        wr_cfg(cfg(20, 2, 0, 1));
        repeat (16) @(negedge clk);
        tick_wait(1);
        exp_hi = '{60};
        dot_key = 1'b1;
        tick_wait(10);
        wr_cfg(cfg(60, 2, 0, 1));
        tick_wait(10);
        dot_key = 1'b0;
        wait_idle("mid_dot_write");
        exp_hi = '{20};
        dot_key = 1'b1;
        tick_wait(29);
        dot_key = 1'b0;
        wait_idle("fast_dot");

        mon_en = 1'b0;
        dot_key = 1'b1;
        tick_wait(5);
        wr_cfg(cfg(60, 2, 0, 0));
        @(negedge clk);
        chk("disable_out", int'(keyer_out), 0);
        chk("disable_active", int'(keyer_active), 0);
        dot_key = 1'b0;
        tick_wait(2);
        mon_en = 1'b1;

        // straight, reversed: the dash paddle keys directly
        wr_cfg(cfg(20, 0, 1, 1));
        tick_wait(1);
        exp_hi = '{37};
        dash_key = 1'b1;
        tick_wait(37);
        dash_key = 1'b0;
        tick_wait(3);
        dot_key = 1'b1;
        tick_wait(10);
        dot_key = 1'b0;
        wait_idle("straight_rev");

        dash_key = 1'b1;
        tick_wait(10);
        chk("straight_on", int'(keyer_out), 1);
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out", int'(keyer_out), 0);
        chk("rst_enable", int'(dut.enable_q), 0);
        chk("rst_mode", int'(dut.mode_q), 2);
        chk("rst_reverse", int'(dut.reverse_q), 0);
        chk("rst_wpm", int'(dut.wpm_q), 20);
        dash_key = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
